interrupt_arbiter: RTL and testbench
====================================

Name: interrupt_arbiter

Overview:
- Upstream feeder of the CSR unit's trap path.
- Synchronizes external interrupt lines and holds the mip pending register.
- Applies mie, mstatus.mie and privilege gating, then selects the highest-priority enabled interrupt.
- Presents the winner as a latched mcause code on a req/ack handshake to the trap logic. Also provides a WFI wake signal and the mip read value.

Parameters:
- SYNC_STAGES, 2, flop depth of each external-line synchronizer (min 2).
- ECODE_W, 5, width of the cause code, matching the mcause code field.

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous active-high reset
- ext_meip  in  1  async machine external interrupt line
- ext_mtip  in  1  async machine timer interrupt line
- ext_msip  in  1  async machine software interrupt line
- mip_wr  in  1  CSR write strobe for mip
- mip_wdata  in  32  CSR write data; only bits 9 (SEIP), 5 (STIP), 1 (SSIP) are writable
- mie  in  32  current mie value, mie_t layout
- mstatus_mie  in  1  global machine interrupt enable
- privilege  in  2  current privilege, privilege_t encoding
- mip_o  out  32  mip read value, mip_t layout
- irq_req  out  1  interrupt request to trap logic
- irq_code  out  ECODE_W  cause code of the request
- irq_ack  in  1  trap logic accepted the request
- trap_done  in  1  single-cycle pulse when the trap entry sequence has committed
- wfi_wake  out  1  (mip & mie) != 0, ignoring global enable

Behaviour:
- Reset is asynchronous, active-high. All flops clear: synchronizers, mip bits, state=IDLE, irq_req=0, irq_code=0, mip_o=0, wfi_wake=0.
- Synchronizers: each external line passes through SYNC_STAGES flops. The output registers into mip MEIP(11)/MTIP(7)/MSIP(3) one cycle later. Latency from a stable line to mip_o is SYNC_STAGES+1 cycles.
- mip_wr: updates SEIP/STIP/SSIP on the next edge. Writes to other bits are ignored. Custom bits [31:16] and all zero fields read 0.
- Enable rule: M-level interrupts are globally enabled when privilege != MACHINE_PRIVILEGE or mstatus_mie=1.
- Pending-enabled vector: mip & mie & {global enable}.
- Priority, highest first: MEI(11), MSI(3), MTI(7), SEI(9), SSI(1), STI(5). The selected code is the bit index, zero-extended to ECODE_W.
- FSM states: IDLE, REQUEST, BLOCKED.
- IDLE: if the pending-enabled vector is nonzero, latch the winning code into irq_code, go to REQUEST, and set irq_req=1 from the next cycle.
- REQUEST: irq_req=1 and irq_code stays stable until acked.
  - irq_ack=1 -> BLOCKED; irq_req drops the next cycle.
  - Vector becomes zero (enable cleared or source deasserted) without ack -> IDLE; irq_req drops the next cycle.
  - Ack and withdrawal in the same cycle: ack wins.
  - A higher-priority source arriving while in REQUEST does not re-latch the code.
- BLOCKED: irq_req=0. trap_done -> IDLE. A new request may issue no earlier than the cycle after IDLE is re-entered.
- irq_ack outside REQUEST is ignored. trap_done outside BLOCKED is ignored.
- wfi_wake is combinational from registered mip and the mie input. It is independent of state.
- Reset mid-handshake: state returns to IDLE asynchronously and irq_req drops immediately.

Optional Feature:
- Macro: INTERRUPT_SUPERVISOR_EN.
- Defined: SEIP/STIP/SSIP are writable and participate in arbitration as above.
- Undefined: those bits are hardwired 0 in mip_o, mip_wr is ignored entirely, and the priority chain is MEI, MSI, MTI only.

Decomposition:
- Shared package (alongside csr_types): interrupt code constants (IRQ_SSI=1, IRQ_STI=5, IRQ_SEI=9, IRQ_MSI=3, IRQ_MTI=7, IRQ_MEI=11), the writable-mask constant for mip, and the arbiter state enum.
- One natural sub-module, interrupt_sync: a parameterized SYNC_STAGES-deep single-bit synchronizer with async reset, instantiated three times.

Test Plan:
- Reset priority: privilege=M, mstatus_mie=1, mie=0x888. Raise ext_mtip and ext_meip in the same cycle -> irq_req rises after SYNC_STAGES+2 cycles with irq_code=11. Ack -> irq_req=0; pulse trap_done -> next request has irq_code=7.
- Global gating: privilege=M, mstatus_mie=0, ext_msip=1, mie=0x8 -> irq_req stays 0 and wfi_wake=1. Switch privilege to U -> irq_req=1, irq_code=3.
- Withdrawal: in REQUEST with code 7, drop mie to 0 before ack -> irq_req=0 next cycle, state IDLE. Assert irq_ack on the same cycle as the mie drop instead -> state BLOCKED.
- Stability: in REQUEST with code 7, raise ext_meip -> irq_code stays 7 until ack. After trap_done, the next request has code 11.
- mip write (macro defined): mip_wr with mip_wdata=0xFFFFFFFF -> mip_o=0x222. Macro undefined -> mip_o=0x000.
- Async reset: assert rst mid-REQUEST -> irq_req=0 without a clock edge. After release, no request until the synchronizers refill.

Source files
------------

// File: rtl/interrupt_arbiter_pkg.sv
// Shared interrupt constants, mip write mask, privilege encoding and arbiter state enum.
package interrupt_arbiter_pkg;

  localparam int IRQ_SSI = 1;
  localparam int IRQ_MSI = 3;
  localparam int IRQ_STI = 5;
  localparam int IRQ_MTI = 7;
  localparam int IRQ_SEI = 9;
  localparam int IRQ_MEI = 11;

  // Software-writable mip bits: SEIP, STIP, SSIP
  localparam logic [31:0] MIP_WMASK = 32'h0000_0222;

  typedef enum logic [1:0] {
    USER_PRIVILEGE       = 2'b00,
    SUPERVISOR_PRIVILEGE = 2'b01,
    MACHINE_PRIVILEGE    = 2'b11
  } privilege_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQUEST = 2'd1,
    BLOCKED = 2'd2
  } arb_state_e;

endpackage

// File: rtl/interrupt_sync.sv
// SYNC_STAGES-deep single-bit synchronizer with asynchronous active-high reset.
module interrupt_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] ff;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ff <= '0;
    else     ff <= {ff[SYNC_STAGES-2:0], d};
  end

  assign q = ff[SYNC_STAGES-1];

endmodule

// File: rtl/interrupt_arbiter.sv
// Interrupt arbiter: syncs external lines, holds mip, gates and prioritizes, req/ack to trap logic.
// Supervisor interrupt bits are enabled by defining INTERRUPT_SUPERVISOR_EN.
module interrupt_arbiter
  import interrupt_arbiter_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int ECODE_W     = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ext_meip,
  input  logic               ext_mtip,
  input  logic               ext_msip,
  input  logic               mip_wr,
  input  logic [31:0]        mip_wdata,
  input  logic [31:0]        mie,
  input  logic               mstatus_mie,
  input  logic [1:0]         privilege,
  output logic [31:0]        mip_o,
  output logic               irq_req,
  output logic [ECODE_W-1:0] irq_code,
  input  logic               irq_ack,
  input  logic               trap_done,
  output logic               wfi_wake
);

  logic meip_s, mtip_s, msip_s;
  logic meip_q, mtip_q, msip_q;
  logic seip_q, stip_q, ssip_q;

  interrupt_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_mei (.clk(clk), .rst(rst), .d(ext_meip), .q(meip_s));
  interrupt_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_mti (.clk(clk), .rst(rst), .d(ext_mtip), .q(mtip_s));
  interrupt_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_msi (.clk(clk), .rst(rst), .d(ext_msip), .q(msip_s));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meip_q <= 1'b0;
      mtip_q <= 1'b0;
      msip_q <= 1'b0;
    end else begin
      meip_q <= meip_s;
      mtip_q <= mtip_s;
      msip_q <= msip_s;
    end
  end

`ifdef INTERRUPT_SUPERVISOR_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seip_q <= 1'b0;
      stip_q <= 1'b0;
      ssip_q <= 1'b0;
    end else if (mip_wr) begin
      seip_q <= mip_wdata[IRQ_SEI];
      stip_q <= mip_wdata[IRQ_STI];
      ssip_q <= mip_wdata[IRQ_SSI];
    end
  end
`else
  assign seip_q = 1'b0;
  assign stip_q = 1'b0;
  assign ssip_q = 1'b0;
`endif

  always_comb begin
    mip_o          = '0;
    mip_o[IRQ_MEI] = meip_q;
    mip_o[IRQ_MTI] = mtip_q;
    mip_o[IRQ_MSI] = msip_q;
    mip_o[IRQ_SEI] = seip_q;
    mip_o[IRQ_STI] = stip_q;
    mip_o[IRQ_SSI] = ssip_q;
  end

  assign wfi_wake = |(mip_o & mie);

  // Below machine mode, M-level interrupts are always globally enabled
  logic        gie;
  logic [31:0] pend_en;
  assign gie     = (privilege != MACHINE_PRIVILEGE) || mstatus_mie;
  assign pend_en = mip_o & mie & {32{gie}};

  logic [ECODE_W-1:0] win_code;
  always_comb begin
    win_code = '0;
    if      (pend_en[IRQ_MEI]) win_code = ECODE_W'(IRQ_MEI);
    else if (pend_en[IRQ_MSI]) win_code = ECODE_W'(IRQ_MSI);
    else if (pend_en[IRQ_MTI]) win_code = ECODE_W'(IRQ_MTI);
`ifdef INTERRUPT_SUPERVISOR_EN
    else if (pend_en[IRQ_SEI]) win_code = ECODE_W'(IRQ_SEI);
    else if (pend_en[IRQ_SSI]) win_code = ECODE_W'(IRQ_SSI);
    else if (pend_en[IRQ_STI]) win_code = ECODE_W'(IRQ_STI);
`endif
  end

  arb_state_e state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      irq_req  <= 1'b0;
      irq_code <= '0;
    end else begin
      case (state)
        IDLE: if (|pend_en) begin
          state    <= REQUEST;
          irq_req  <= 1'b1;
          irq_code <= win_code;
        end
        // Ack takes precedence over a same-cycle withdrawal; code is never re-latched here
        REQUEST: if (irq_ack) begin
          state   <= BLOCKED;
          irq_req <= 1'b0;
        end else if (pend_en == '0) begin
          state   <= IDLE;
          irq_req <= 1'b0;
        end
        BLOCKED: if (trap_done) state <= IDLE;
        default: begin
          state   <= IDLE;
          irq_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_interrupt_arbiter.sv
// Directed bench for interrupt_arbiter; optionally built with INTERRUPT_SUPERVISOR_EN.
module tb_interrupt_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        ext_meip, ext_mtip, ext_msip;
  logic        mip_wr;
  logic [31:0] mip_wdata;
  logic [31:0] mie;
  logic        mstatus_mie;
  logic [1:0]  privilege;
  logic [31:0] mip_o;
  logic        irq_req;
  logic [4:0]  irq_code;
  logic        irq_ack;
  logic        trap_done;
  logic        wfi_wake;

  int n_assert = 0;
  int n_fail   = 0;

  interrupt_arbiter #(.SYNC_STAGES(2), .ECODE_W(5)) dut (
    .clk(clk), .rst(rst),
    .ext_meip(ext_meip), .ext_mtip(ext_mtip), .ext_msip(ext_msip),
    .mip_wr(mip_wr), .mip_wdata(mip_wdata), .mie(mie),
    .mstatus_mie(mstatus_mie), .privilege(privilege),
    .mip_o(mip_o), .irq_req(irq_req), .irq_code(irq_code),
    .irq_ack(irq_ack), .trap_done(trap_done), .wfi_wake(wfi_wake)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic ack_once();
    irq_ack = 1'b1;
    cyc(1);
    irq_ack = 1'b0;
  endtask

  task automatic done_once();
    trap_done = 1'b1;
    cyc(1);
    trap_done = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    {ext_meip, ext_mtip, ext_msip} = 3'b000;
    mip_wr = 1'b0; mip_wdata = '0; mie = '0;
    mstatus_mie = 1'b0; privilege = 2'b11;
    irq_ack = 1'b0; trap_done = 1'b0;
    #1;
    check("rst_req", {31'b0, irq_req}, 32'h0);
    check("rst_code", {27'b0, irq_code}, 32'h0);
    check("rst_mip", mip_o, 32'h0);
    check("rst_wake", {31'b0, wfi_wake}, 32'h0);
    cyc(2);
    rst = 1'b0;

    // Priority: MEI beats MTI when both arrive together
    mstatus_mie = 1'b1; mie = 32'h888;
    ext_meip = 1'b1; ext_mtip = 1'b1;
    cyc(3);
    check("prio_mip", mip_o, 32'h880);
    check("prio_req_early", {31'b0, irq_req}, 32'h0);
    cyc(1);
    check("prio_req", {31'b0, irq_req}, 32'h1);
    check("prio_code", {27'b0, irq_code}, 32'd11);
    ext_meip = 1'b0;
    ack_once();
    check("prio_ack_drop", {31'b0, irq_req}, 32'h0);
    cyc(4);
    check("prio_blocked", {31'b0, irq_req}, 32'h0);
    done_once();
    check("prio_idle", {31'b0, irq_req}, 32'h0);
    cyc(1);
    check("prio_next_req", {31'b0, irq_req}, 32'h1);
    check("prio_next_code", {27'b0, irq_code}, 32'd7);

    // Stability: a later MEI does not re-latch the code
    ext_meip = 1'b1;
    cyc(5);
    check("stab_req", {31'b0, irq_req}, 32'h1);
    check("stab_code", {27'b0, irq_code}, 32'd7);
    ack_once();
    done_once();
    cyc(1);
    check("stab_next_code", {27'b0, irq_code}, 32'd11);
    check("stab_next_req", {31'b0, irq_req}, 32'h1);
    ext_meip = 1'b0;
    ack_once();
    cyc(4);
    done_once();
    cyc(1);
    check("mti_again_code", {27'b0, irq_code}, 32'd7);

    // Withdrawal via mie drop returns to IDLE
    mie = 32'h0;
    cyc(1);
    check("wd_drop", {31'b0, irq_req}, 32'h0);
    mie = 32'h888;
    cyc(1);
    check("wd_reissue", {31'b0, irq_req}, 32'h1);
    check("wd_reissue_code", {27'b0, irq_code}, 32'd7);
    // Ack with simultaneous withdrawal goes to BLOCKED
    mie = 32'h0; irq_ack = 1'b1;
    cyc(1);
    irq_ack = 1'b0; mie = 32'h888;
    check("wd_ack_drop", {31'b0, irq_req}, 32'h0);
    cyc(2);
    check("wd_blocked", {31'b0, irq_req}, 32'h0);
    check("wd_wake", {31'b0, wfi_wake}, 32'h1);
    done_once();
    cyc(1);
    check("wd_after_done", {31'b0, irq_req}, 32'h1);
    ext_mtip = 1'b0;
    ack_once();
    cyc(4);
    done_once();
    cyc(2);
    check("clear_req", {31'b0, irq_req}, 32'h0);
    check("clear_mip", mip_o, 32'h0);

    // Global gating in M-mode, released by dropping to U-mode
    mstatus_mie = 1'b0; mie = 32'h8; ext_msip = 1'b1;
    cyc(5);
    check("gate_req", {31'b0, irq_req}, 32'h0);
    check("gate_wake", {31'b0, wfi_wake}, 32'h1);
    privilege = 2'b00;
    cyc(1);
    check("gate_u_req", {31'b0, irq_req}, 32'h1);
    check("gate_u_code", {27'b0, irq_code}, 32'd3);

    // Async reset mid-REQUEST
    #2 rst = 1'b1;
    #1;
    check("arst_req", {31'b0, irq_req}, 32'h0);
    check("arst_mip", mip_o, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    cyc(3);
    check("arst_refill", {31'b0, irq_req}, 32'h0);
    cyc(1);
    check("arst_req_back", {31'b0, irq_req}, 32'h1);
    check("arst_code", {27'b0, irq_code}, 32'd3);
    ext_msip = 1'b0;
    ack_once();
    cyc(4);
    done_once();
    cyc(1);

    // mip software write; only supervisor bits stick
    mip_wr = 1'b1; mip_wdata = 32'hFFFF_FFFF;
    cyc(1);
    mip_wr = 1'b0; mip_wdata = '0;
`ifdef INTERRUPT_SUPERVISOR_EN
    check("mip_write", mip_o, 32'h222);
`else
    check("mip_write", mip_o, 32'h000);
`endif
    check("mip_write_req", {31'b0, irq_req}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
